// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall detection, forwarding selects for D/E/M
// consumers, and the mult/div busy countdown that blocks HI/LO access.
module hazard_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] Tuse_rs_D,
   input  logic [1:0] Tuse_rt_D,
   input  logic [4:0] A3_D,
   input  logic [1:0] Tnew_D,
   input  logic [1:0] src_D,
   input  logic       md_start_D,
   input  logic       md_div_D,
   input  logic       md_use_D,
   output logic       stall,
   output logic [2:0] forwardRSD,
   output logic [2:0] forwardRTD,
   output logic [2:0] forwardRSE,
   output logic [2:0] forwardRTE,
   output logic [1:0] forwardRTM,
   output logic       md_busy
);

   localparam logic [1:0] SRC_PC8 = 2'd1;
   localparam logic [3:0] MUL_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES = 4'd10;

   logic [4:0] a3_e, rs_e, rt_e, a3_m, rt_m, a3_w;
   logic [1:0] tnew_e, src_e, tnew_m, src_m, src_w;
   logic       md_start_e, md_div_e;
   logic [3:0] md_cnt;
   logic       stall_raw;

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] a3e, input logic [1:0] tne,
                                     input logic [4:0] a3m, input logic [1:0] tnm);
      logic hit;
      hit = 1'b0;
      if (r != 5'd0 && tuse != 2'd3) begin
         if (a3e == r && tuse < tne) hit = 1'b1;
         if (a3m == r && tuse < tnm) hit = 1'b1;
      end
      return hit;
   endfunction

   // M beats W; an M producer only forwards once its result has arrived.
   function automatic logic [2:0] fwd_sel(input logic [4:0] r,
                                          input logic [4:0] a3m, input logic [1:0] tnm,
                                          input logic [1:0] srcm,
                                          input logic [4:0] a3w, input logic [1:0] srcw);
      logic [2:0] sel;
      sel = 3'd0;
      if (r != 5'd0) begin
         if (a3m == r && tnm == 2'd0)
            sel = (srcm == SRC_PC8) ? 3'd2 : 3'd1;
         else if (a3w == r)
            sel = (srcw == SRC_PC8) ? 3'd4 : 3'd3;
      end
      return sel;
   endfunction

   always_comb begin
      stall_raw = op_stall(rs_D, Tuse_rs_D, a3_e, tnew_e, a3_m, tnew_m)
                | op_stall(rt_D, Tuse_rt_D, a3_e, tnew_e, a3_m, tnew_m)
                | (md_use_D & ((md_cnt != 4'd0) | md_start_e));
      stall      = 1'b0;
      forwardRSD = 3'd0;
      forwardRTD = 3'd0;
      forwardRSE = 3'd0;
      forwardRTE = 3'd0;
      forwardRTM = 2'd0;
      md_busy    = 1'b0;
      if (!reset) begin
         stall      = stall_raw;
         forwardRSD = fwd_sel(rs_D, a3_m, tnew_m, src_m, a3_w, src_w);
         forwardRTD = fwd_sel(rt_D, a3_m, tnew_m, src_m, a3_w, src_w);
         forwardRSE = fwd_sel(rs_e, a3_m, tnew_m, src_m, a3_w, src_w);
         forwardRTE = fwd_sel(rt_e, a3_m, tnew_m, src_m, a3_w, src_w);
         if (rt_m != 5'd0 && a3_w == rt_m)
            forwardRTM = (src_w == SRC_PC8) ? 2'd2 : 2'd1;
         md_busy    = (md_cnt != 4'd0);
      end
   end

   // D -> E (bubble on stall), E -> M, M -> W, and the mult/div countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         a3_e <= '0; rs_e <= '0; rt_e <= '0; tnew_e <= '0; src_e <= '0;
         md_start_e <= 1'b0; md_div_e <= 1'b0;
         a3_m <= '0; rt_m <= '0; tnew_m <= '0; src_m <= '0;
         a3_w <= '0; src_w <= '0;
         md_cnt <= '0;
      end else begin
         if (stall_raw) begin
            a3_e <= '0; rs_e <= '0; rt_e <= '0; tnew_e <= '0; src_e <= '0;
            md_start_e <= 1'b0; md_div_e <= 1'b0;
         end else begin
            a3_e <= A3_D; rs_e <= rs_D; rt_e <= rt_D; tnew_e <= Tnew_D; src_e <= src_D;
            md_start_e <= md_start_D; md_div_e <= md_div_D;
         end
         a3_m   <= a3_e;
         rt_m   <= rt_e;
         tnew_m <= sat_dec(tnew_e);
         src_m  <= src_e;
         a3_w   <= a3_m;
         src_w  <= src_m;
         if (md_start_e)
            md_cnt <= md_div_e ? DIV_CYCLES : MUL_CYCLES;
         else if (md_cnt != 4'd0)
            md_cnt <= md_cnt - 4'd1;
      end
   end

endmodule
